// File: rtl/msdap_main_ctrl.sv
// msdap_main_ctrl: sequences the MSDAP core through clear, Rj load, coefficient load, sample
//    processing and sleep, driving memory write strobes and the compute-unit start pulse.
// Latency: word_valid at cycle t -> write enable/address valid at t+1, mac_start at t+2.
// Backpressure: none; InReady advertises acceptance, and a word arriving while a sample is
//    still being computed is processed anyway and flags the sticky overrun bit.
//
// Ports:
//    Sclk, Reset_n          clock, asynchronous active-low reset
//    Start                  synchronous full re-initialisation (also forgets the loaded config)
//    word_valid, word_zero  word-pair strobe from the deserialisers, and "both words are zero"
//    mac_done               compute unit finished the current sample
//    InReady                chip accepts words (every state except CLEAR)
//    rj_we, coef_we         Rj / coefficient memory write enables, address on wr_addr
//    data_we, data_clr      data memory write (at data_ptr) / clear (at wr_addr)
//    wr_addr, data_ptr      load/clear address, ring index of the newest sample
//    mac_start              start computing the sample at data_ptr
//    sleep, overrun, state  status and debug

module msdap_main_ctrl #(
   parameter int RJ_DEPTH   = 16,
   parameter int COEF_DEPTH = 512,
   parameter int DATA_DEPTH = 256,
   parameter int ZERO_RUN   = 800
) (
   input  logic       Sclk,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic       word_valid,
   input  logic       word_zero,
   input  logic       mac_done,
   output logic       InReady,
   output logic       rj_we,
   output logic       coef_we,
   output logic       data_we,
   output logic       data_clr,
   output logic [8:0] wr_addr,
   output logic [7:0] data_ptr,
   output logic       mac_start,
   output logic       sleep,
   output logic       overrun,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      CLEAR     = 4'd0,
      WAIT_RJ   = 4'd1,
      READ_RJ   = 4'd2,
      WAIT_COEF = 4'd3,
      READ_COEF = 4'd4,
      WAIT_DATA = 4'd5,
      WORKING   = 4'd6,
      SLEEP     = 4'd7
   } state_t;

   localparam int ZW = $clog2(ZERO_RUN + 1);

   localparam logic [8:0]    RJ_LAST   = 9'(RJ_DEPTH - 1);
   localparam logic [8:0]    COEF_LAST = 9'(COEF_DEPTH - 1);
   localparam logic [8:0]    CLR_LAST  = 9'(DATA_DEPTH - 1);
   localparam logic [7:0]    PTR_LAST  = 8'(DATA_DEPTH - 1);
   localparam logic [ZW-1:0] ZMAX      = ZW'(ZERO_RUN);

   state_t        state_q, state_d;
   logic [8:0]    wr_addr_q, wr_addr_d;
   logic [7:0]    data_ptr_q, data_ptr_d;
   logic [ZW-1:0] zcnt_q, zcnt_d;
   logic          seen_q, seen_d;          // at least one sample written since CLEAR
   logic          outst_q, outst_d;        // a sample is with the compute unit
   logic          mac_req_q, mac_req_d;    // delays mac_start one cycle behind data_we
   logic          rj_we_q, rj_we_d;
   logic          coef_we_q, coef_we_d;
   logic          data_we_q, data_we_d;
   logic          data_clr_q, data_clr_d;
   logic          mac_start_q, mac_start_d;
   logic          in_ready_q, in_ready_d;
   logic          sleep_q, sleep_d;
   logic          overrun_q, overrun_d;
   logic          cfg_loaded_q, cfg_loaded_d;
   logic          proc_word;
   logic [8:0]    addr_inc;

   assign addr_inc = wr_addr_q + 9'd1;

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      data_ptr_d   = data_ptr_q;
      zcnt_d       = zcnt_q;
      seen_d       = seen_q;
      // mac_done retires the outstanding sample before the overrun check below
      outst_d      = outst_q & ~mac_done;
      overrun_d    = overrun_q;
      cfg_loaded_d = cfg_loaded_q;
      mac_req_d    = 1'b0;
      rj_we_d      = 1'b0;
      coef_we_d    = 1'b0;
      data_we_d    = 1'b0;
      data_clr_d   = 1'b0;
      mac_start_d  = mac_req_q & ~Start;
      proc_word    = 1'b0;

      if (word_valid && outst_q && !mac_done) begin
         overrun_d = 1'b1;
      end

      if (Start) begin
         // Start outranks any word arriving in the same cycle
         state_d      = CLEAR;
         wr_addr_d    = 9'd0;
         cfg_loaded_d = 1'b0;
         overrun_d    = 1'b0;
         outst_d      = 1'b0;
         data_ptr_d   = 8'd0;
         zcnt_d       = '0;
         seen_d       = 1'b0;
      end else begin
         unique case (state_q)
            CLEAR: begin
               data_ptr_d = 8'd0;
               zcnt_d     = '0;
               seen_d     = 1'b0;
               outst_d    = 1'b0;
               // data_clr low inside CLEAR means the sweep has not begun yet
               if (!data_clr_q) begin
                  data_clr_d = 1'b1;
                  wr_addr_d  = 9'd0;
               end else if (wr_addr_q == CLR_LAST) begin
                  wr_addr_d = 9'd0;
                  state_d   = cfg_loaded_q ? WAIT_DATA : WAIT_RJ;
               end else begin
                  data_clr_d = 1'b1;
                  wr_addr_d  = addr_inc;
               end
            end
            WAIT_RJ: begin
               if (word_valid) begin
                  rj_we_d   = 1'b1;
                  wr_addr_d = 9'd0;
                  state_d   = (RJ_LAST == 9'd0) ? WAIT_COEF : READ_RJ;
               end
            end
            READ_RJ: begin
               if (word_valid) begin
                  rj_we_d   = 1'b1;
                  wr_addr_d = addr_inc;
                  if (addr_inc == RJ_LAST) begin
                     state_d = WAIT_COEF;
                  end
               end
            end
            WAIT_COEF: begin
               if (word_valid) begin
                  coef_we_d = 1'b1;
                  wr_addr_d = 9'd0;
                  if (COEF_LAST == 9'd0) begin
                     cfg_loaded_d = 1'b1;
                     state_d      = WAIT_DATA;
                  end else begin
                     state_d = READ_COEF;
                  end
               end
            end
            READ_COEF: begin
               if (word_valid) begin
                  coef_we_d = 1'b1;
                  wr_addr_d = addr_inc;
                  if (addr_inc == COEF_LAST) begin
                     cfg_loaded_d = 1'b1;
                     state_d      = WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               if (word_valid) begin
                  proc_word = 1'b1;
                  state_d   = WORKING;
               end
            end
            WORKING: begin
               proc_word = word_valid;
               // Sleep once the sample completing the zero run is computed, unless a
               // nonzero word arriving in that same cycle breaks the run.
               if (mac_done && zcnt_q == ZMAX && !(word_valid && !word_zero)) begin
                  state_d = SLEEP;
               end
            end
            SLEEP: begin
               if (word_valid && !word_zero) begin
                  proc_word = 1'b1;
                  state_d   = WORKING;
               end
            end
            default: state_d = CLEAR;
         endcase

         if (proc_word) begin
            data_we_d = 1'b1;
            mac_req_d = 1'b1;
            outst_d   = 1'b1;
            seen_d    = 1'b1;
            // the first sample after CLEAR lands at index 0 without advancing
            if (seen_q) begin
               data_ptr_d = (data_ptr_q == PTR_LAST) ? 8'd0 : data_ptr_q + 8'd1;
            end
            if (!word_zero) begin
               zcnt_d = '0;
            end else if (zcnt_q != ZMAX) begin
               zcnt_d = zcnt_q + ZW'(1);
            end
         end
      end

      in_ready_d = (state_d != CLEAR);
      sleep_d    = (state_d == SLEEP);
   end

   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= CLEAR;
         wr_addr_q   <= 9'd0;
         data_ptr_q  <= 8'd0;
         zcnt_q      <= '0;
         seen_q      <= 1'b0;
         outst_q     <= 1'b0;
         mac_req_q   <= 1'b0;
         rj_we_q     <= 1'b0;
         coef_we_q   <= 1'b0;
         data_we_q   <= 1'b0;
         data_clr_q  <= 1'b0;
         mac_start_q <= 1'b0;
         in_ready_q  <= 1'b0;
         sleep_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         data_ptr_q  <= data_ptr_d;
         zcnt_q      <= zcnt_d;
         seen_q      <= seen_d;
         outst_q     <= outst_d;
         mac_req_q   <= mac_req_d;
         rj_we_q     <= rj_we_d;
         coef_we_q   <= coef_we_d;
         data_we_q   <= data_we_d;
         data_clr_q  <= data_clr_d;
         mac_start_q <= mac_start_d;
         in_ready_q  <= in_ready_d;
         sleep_q     <= sleep_d;
         overrun_q   <= overrun_d;
      end
   end

   // Loaded configuration survives Reset_n so a mid-stream reset skips the reload;
   // only Start forgets it.
   always_ff @(posedge Sclk) begin
      cfg_loaded_q <= cfg_loaded_d;
   end

   assign InReady   = in_ready_q;
   assign rj_we     = rj_we_q;
   assign coef_we   = coef_we_q;
   assign data_we   = data_we_q;
   assign data_clr  = data_clr_q;
   assign wr_addr   = wr_addr_q;
   assign data_ptr  = data_ptr_q;
   assign mac_start = mac_start_q;
   assign sleep     = sleep_q;
   assign overrun   = overrun_q;
   assign state     = state_q;

endmodule
